// File: rtl/bresenham_pkg.sv
// -----------------------------------------------------------------------------
// bresenham_pkg
// Shared definitions for the line rasteriser path: the default coordinate
// width, the line engine state encoding, and the pixel record that travels
// between bresenham_controller, bresenham_line_engine and the framebuffer
// writer.
// -----------------------------------------------------------------------------
package bresenham_pkg;

  localparam int COORD_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } bla_state_t;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
  } pixel_t;

endpackage : bresenham_pkg

// File: rtl/bla_err_step.sv
// -----------------------------------------------------------------------------
// bla_err_step
// One combinational Bresenham step: given the current pixel, error term,
// step magnitudes and directions, produce the next pixel and error term.
//
// Ports:
//   cur_x_i, cur_y_i   current pixel coordinate
//   err_i              current error term (signed, COORD_W+2 bits)
//   dx_i               |x1-x0|, non-negative
//   dy_i               -|y1-y0|, non-positive
//   sx_neg_i, sy_neg_i 1 = step towards smaller coordinates
//   nxt_x_o, nxt_y_o   next pixel coordinate
//   nxt_err_o          next error term
// -----------------------------------------------------------------------------
module bla_err_step #(
  parameter int COORD_W = 8
) (
  input  logic        [COORD_W-1:0] cur_x_i,
  input  logic        [COORD_W-1:0] cur_y_i,
  input  logic signed [COORD_W+1:0] err_i,
  input  logic signed [COORD_W+1:0] dx_i,
  input  logic signed [COORD_W+1:0] dy_i,
  input  logic                      sx_neg_i,
  input  logic                      sy_neg_i,
  output logic        [COORD_W-1:0] nxt_x_o,
  output logic        [COORD_W-1:0] nxt_y_o,
  output logic signed [COORD_W+1:0] nxt_err_o
);

  logic signed [COORD_W+1:0] e2;

  // Both tests use the error term from before this step, so e2 is fixed
  // while the two adjustments accumulate into nxt_err_o.
  assign e2 = err_i <<< 1;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (no latch); blocking assignments let the second adjustment build on the
    // first within the same evaluation.
    nxt_x_o   = cur_x_i;
    nxt_y_o   = cur_y_i;
    nxt_err_o = err_i;

    if (e2 >= dy_i) begin
      nxt_err_o = nxt_err_o + dy_i;
      nxt_x_o   = sx_neg_i ? cur_x_i - 1'b1 : cur_x_i + 1'b1;
    end

    if (e2 <= dx_i) begin
      nxt_err_o = nxt_err_o + dx_i;
      nxt_y_o   = sy_neg_i ? cur_y_i - 1'b1 : cur_y_i + 1'b1;
    end
  end

endmodule : bla_err_step

// File: rtl/bresenham_line_engine.sv
// -----------------------------------------------------------------------------
// bresenham_line_engine
// Rasterises one line segment per request with integer Bresenham stepping and
// streams one pixel per cycle under a valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   draw_en              start request, honoured only in IDLE
//   x0, y0, x1, y1       segment endpoints, latched when draw_en is accepted
//   pix_ready            downstream accepts the presented pixel
//   pix_valid            pix_x/pix_y carry a pixel (DRAW state)
//   pix_x, pix_y         current pixel
//   busy                 request accepted and segment not yet finished
//   draw_done            one-cycle pulse after the last pixel is accepted
//   pix_count            (BLA_PIXEL_COUNT_EN only) pixels accepted this line
//
// Build option: define BLA_PIXEL_COUNT_EN to add the pix_count output.
//
// All outputs decode from registers only, so pix_ready never reaches
// pix_x/pix_y combinationally.
// -----------------------------------------------------------------------------
module bresenham_line_engine
  import bresenham_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               draw_en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               busy,
`ifdef BLA_PIXEL_COUNT_EN
  output logic [COORD_W:0]   pix_count,
`endif
  output logic               draw_done
);

  localparam int EW = COORD_W + 2;

  bla_state_t state_q, state_d;

  logic        [COORD_W-1:0] cur_x_q, cur_x_d;
  logic        [COORD_W-1:0] cur_y_q, cur_y_d;
  logic        [COORD_W-1:0] end_x_q, end_x_d;
  logic        [COORD_W-1:0] end_y_q, end_y_d;
  logic signed [EW-1:0]      dx_q, dx_d;
  logic signed [EW-1:0]      dy_q, dy_d;
  logic signed [EW-1:0]      err_q, err_d;
  logic                      sx_neg_q, sx_neg_d;
  logic                      sy_neg_q, sy_neg_d;
`ifdef BLA_PIXEL_COUNT_EN
  logic        [COORD_W:0]   cnt_q, cnt_d;
`endif

  logic        [COORD_W-1:0] abs_x, abs_y;
  logic        [COORD_W-1:0] step_x, step_y;
  logic signed [EW-1:0]      step_err;

  // During SETUP cur holds (x0,y0) and end holds (x1,y1).
  assign abs_x = (end_x_q >= cur_x_q) ? end_x_q - cur_x_q : cur_x_q - end_x_q;
  assign abs_y = (end_y_q >= cur_y_q) ? end_y_q - cur_y_q : cur_y_q - end_y_q;

  bla_err_step #(
    .COORD_W (COORD_W)
  ) u_err_step (
    .cur_x_i   (cur_x_q),
    .cur_y_i   (cur_y_q),
    .err_i     (err_q),
    .dx_i      (dx_q),
    .dy_i      (dy_q),
    .sx_neg_i  (sx_neg_q),
    .sy_neg_i  (sy_neg_q),
    .nxt_x_o   (step_x),
    .nxt_y_o   (step_y),
    .nxt_err_o (step_err)
  );

  assign pix_x = cur_x_q;
  assign pix_y = cur_y_q;
`ifdef BLA_PIXEL_COUNT_EN
  assign pix_count = cnt_q;
`endif

  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    end_x_d   = end_x_q;
    end_y_d   = end_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    err_d     = err_q;
    sx_neg_d  = sx_neg_q;
    sy_neg_d  = sy_neg_q;
`ifdef BLA_PIXEL_COUNT_EN
    cnt_d     = cnt_q;
`endif
    pix_valid = 1'b0;
    busy      = 1'b0;
    draw_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (draw_en) begin
          cur_x_d = x0;
          cur_y_d = y0;
          end_x_d = x1;
          end_y_d = y1;
`ifdef BLA_PIXEL_COUNT_EN
          cnt_d   = '0;
`endif
          state_d = SETUP;
        end
      end

      SETUP: begin
        busy     = 1'b1;
        dx_d     = $signed({2'b00, abs_x});
        dy_d     = -$signed({2'b00, abs_y});
        err_d    = dx_d + dy_d;
        sx_neg_d = !(cur_x_q < end_x_q);
        sy_neg_d = !(cur_y_q < end_y_q);
        state_d  = DRAW;
      end

      DRAW: begin
        busy      = 1'b1;
        pix_valid = 1'b1;
        if (pix_ready) begin
`ifdef BLA_PIXEL_COUNT_EN
          cnt_d = cnt_q + 1'b1;
`endif
          if (cur_x_q == end_x_q && cur_y_q == end_y_q) begin
            state_d = DONE;
          end else begin
            cur_x_d = step_x;
            cur_y_d = step_y;
            err_d   = step_err;
          end
        end
      end

      DONE: begin
        draw_done = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
`ifdef BLA_PIXEL_COUNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
`ifdef BLA_PIXEL_COUNT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule : bresenham_line_engine

// File: tb/tb_bresenham_line_engine.sv
// -----------------------------------------------------------------------------
// tb_bresenham_line_engine
// Directed lines with hand-computed pixel lists. The stimulus pushes the
// expected pixels into a queue; an independent monitor pops one per accepted
// pixel and compares. Completion timing, busy/draw_done and reset behaviour
// are checked by the stimulus thread.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bresenham_line_engine;
  import bresenham_pkg::*;

  logic       clk;
  logic       rst;
  logic       draw_en;
  logic [7:0] x0, y0, x1, y1;
  logic       pix_ready;
  logic       pix_valid;
  logic [7:0] pix_x, pix_y;
  logic       busy;
  logic       draw_done;
`ifdef BLA_PIXEL_COUNT_EN
  logic [8:0] pix_count;
`endif

  bresenham_line_engine #(.COORD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .draw_en   (draw_en),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
`ifdef BLA_PIXEL_COUNT_EN
    .pix_count (pix_count),
`endif
    .draw_done (draw_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  pixel_t exp_q[$];

  int         stall_left = 0;
  logic [7:0] stall_x    = '0;
  logic [7:0] stall_y    = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_pix(input logic [7:0] px, input logic [7:0] py);
    pixel_t p;
    p.x = px;
    p.y = py;
    exp_q.push_back(p);
  endtask

  // Ready driver: holds pix_ready low for stall_left cycles while the
  // chosen pixel is presented, otherwise keeps it high.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && pix_valid === 1'b1 &&
          pix_x == stall_x && pix_y == stall_y) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  // Monitor: every pixel that will be accepted at the next edge is compared
  // against the head of the scoreboard; a stalled pixel must equal the head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && pix_valid === 1'b1) begin
        if (pix_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pixel_unexpected: got (%0d,%0d) expected none at %0t",
                     pix_x, pix_y, $time);
          end else begin
            pixel_t e;
            e = exp_q.pop_front();
            check("pixel", {16'h0, pix_x, pix_y}, {16'h0, e});
          end
        end else if (exp_q.size() > 0) begin
          check("stall_hold", {16'h0, pix_x, pix_y}, {16'h0, exp_q[0]});
        end
      end
    end
  end

  // Starts a line and checks handshake timing through draw_done. The
  // expected pixels must already be queued.
  task automatic run_line(input logic [7:0] ax, input logic [7:0] ay,
                          input logic [7:0] bx, input logic [7:0] by,
                          input int npix, input int nstall, input bit inject);
    int k;
    bit seen;
    @(negedge clk);
    x0 = ax; y0 = ay; x1 = bx; y1 = by;
    draw_en = 1'b1;
    @(posedge clk);
    #1;
    draw_en = 1'b0;
    // Endpoints are free to change once the request is taken.
    x0 = ~ax; y0 = ~ay; x1 = ~bx; y1 = ~by;
    check("busy_after_start", {31'h0, busy}, 32'd1);
    check("valid_in_setup", {31'h0, pix_valid}, 32'd0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) check("first_valid", {31'h0, pix_valid}, 32'd1);
      if (inject) begin
        if (k == 2) begin
          draw_en = 1'b1;
          x0 = 8'd9; y0 = 8'd9; x1 = 8'd2; y1 = 8'd2;
        end else if (k == 3) begin
          draw_en = 1'b0;
        end
      end
      if (draw_done === 1'b1) seen = 1'b1;
    end
    check("draw_done_seen", {31'h0, seen}, 32'd1);
    check("done_latency", k, 1 + npix + nstall);
    check("busy_at_done", {31'h0, busy}, 32'd0);
    check("pixels_left", exp_q.size(), 32'd0);
`ifdef BLA_PIXEL_COUNT_EN
    check("pix_count", {23'h0, pix_count}, npix);
`endif
    @(posedge clk);
    #1;
    check("done_one_cycle", {31'h0, draw_done}, 32'd0);
    check("idle_busy", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_any;
    rst = 1'b1;
    draw_en = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    #22;
    check("rst_pix_valid", {31'h0, pix_valid}, 32'd0);
    check("rst_pix_x", {24'h0, pix_x}, 32'd0);
    check("rst_pix_y", {24'h0, pix_y}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_draw_done", {31'h0, draw_done}, 32'd0);
`ifdef BLA_PIXEL_COUNT_EN
    check("rst_pix_count", {23'h0, pix_count}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Horizontal line.
    push_pix(0, 0); push_pix(1, 0); push_pix(2, 0); push_pix(3, 0);
    run_line(8'd0, 8'd0, 8'd3, 8'd0, 4, 0, 1'b0);

    // Steep line towards smaller x and y.
    push_pix(5, 5); push_pix(5, 4); push_pix(4, 3);
    push_pix(4, 2); push_pix(3, 1); push_pix(3, 0);
    run_line(8'd5, 8'd5, 8'd3, 8'd0, 6, 0, 1'b0);

    // Degenerate single-pixel line.
    push_pix(7, 9);
    run_line(8'd7, 8'd9, 8'd7, 8'd9, 1, 0, 1'b0);

    // Backpressure: (1,0) held for three cycles.
    stall_x = 8'd1;
    stall_y = 8'd0;
    stall_left = 3;
    push_pix(0, 0); push_pix(1, 0); push_pix(2, 0); push_pix(3, 0);
    run_line(8'd0, 8'd0, 8'd3, 8'd0, 4, 3, 1'b0);

    // A second request during DRAW must not disturb the stream.
    push_pix(0, 0); push_pix(1, 0); push_pix(2, 0); push_pix(3, 0);
    run_line(8'd0, 8'd0, 8'd3, 8'd0, 4, 0, 1'b1);

    // Reset in the middle of a line.
    push_pix(10, 2); push_pix(11, 2); push_pix(12, 2); push_pix(13, 2);
    @(negedge clk);
    x0 = 8'd10; y0 = 8'd2; x1 = 8'd13; y1 = 8'd2;
    draw_en = 1'b1;
    @(posedge clk);
    #1;
    draw_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_pix_valid", {31'h0, pix_valid}, 32'd0);
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_pix_x", {24'h0, pix_x}, 32'd0);
    check("midrst_accepted", exp_q.size(), 32'd2);
    exp_q.delete();
    done_any = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (draw_done !== 1'b0) done_any = 1'b1;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (draw_done !== 1'b0 || pix_valid !== 1'b0) done_any = 1'b1;
    end
    check("midrst_no_done", {31'h0, done_any}, 32'd0);

    // Full-range diagonal.
    for (int i = 0; i < 256; i++) push_pix(i[7:0], i[7:0]);
    run_line(8'd0, 8'd0, 8'd255, 8'd255, 256, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bresenham_line_engine

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Rasterises one line segment per request using integer Bresenham stepping and streams one pixel coordinate per cycle to the framebuffer write stage. It sits directly downstream of `bresenham_controller`, which sequences polygon edges into `x0/y0/x1/y1` plus a `draw_en` request. This block returns `draw_done` to the controller when the segment is finished. It supports downstream backpressure, so no pixel is ever dropped.

## Interface
- `COORD_W`, default 8: width of each coordinate. The internal error term is signed and `COORD_W+2` bits wide.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `draw_en`  in  1  start request. Sampled only in IDLE.
- `x0`, `y0`, `x1`, `y1`  in  `COORD_W` each  segment endpoints, unsigned. Latched on an accepted `draw_en`.
- `pix_ready`  in  1  downstream can accept a pixel this cycle.
- `pix_valid`  out  1  `pix_x`/`pix_y` hold a valid pixel.
- `pix_x`, `pix_y`  out  `COORD_W` each  current pixel coordinate.
- `busy`  out  1  high from the accepted `draw_en` until the cycle `draw_done` is asserted.
- `draw_done`  out  1  single-cycle pulse after the last pixel is accepted.

## Operation
- **States:** IDLE, SETUP, DRAW, DONE.
- **IDLE:** on `draw_en`, latch all four endpoints, set `busy`, go to SETUP.
- **SETUP:** compute the step terms, then go to DRAW. Cur=(x0,y0).
  - dx=|x1-x0|, dy=-|y1-y0|
  - sx=+1 if x0<x1, else -1; sy=+1 if y0<y1, else -1
  - err=dx+dy
- **DRAW:** `pix_valid`=1 and `pix_x/pix_y`=cur.
  - A handshake occurs when `pix_valid & pix_ready`.
  - On a handshake with cur==(x1,y1), go to DONE.
  - Otherwise, on a handshake, compute e2=2·err and apply both conditions using the old err:
    - if e2≥dy: err+=dy, x+=sx
    - if e2≤dx: err+=dx, y+=sy
- **DONE:** `draw_done`=1 for one cycle, `busy`=0, go to IDLE.
- **Arithmetic:** all error arithmetic is signed `COORD_W+2` bits. No overflow is possible for any endpoints in 0..2^`COORD_W`-1.
- **Boundary conditions:**
  - x0==x1 and y0==y1: exactly one pixel is emitted, then `draw_done`.
  - `draw_en` in SETUP, DRAW or DONE is ignored. It is not queued.
  - Endpoint inputs may change freely after acceptance.
  - Reset mid-line: immediate return to IDLE with all outputs 0 and no `draw_done`.

## Timing
- Reset values: `pix_valid`=0, `pix_x`=0, `pix_y`=0, `busy`=0, `draw_done`=0, state=IDLE.
- `draw_en` high at edge N: `busy` is high after edge N, and the first `pix_valid` is high after edge N+1.
- Throughput is one pixel per cycle while `pix_ready`=1. A line of P pixels with no stalls gives its last handshake at edge N+1+P and a `draw_done` pulse after that edge.
- While `pix_valid & !pix_ready`, `pix_x`/`pix_y` and err hold stable. There are no combinational paths from `pix_ready` to `pix_x`/`pix_y`.
- A new `draw_en` is accepted at earliest the edge after `draw_done` (IDLE).

## Configuration
- `BLA_PIXEL_COUNT_EN` defined: adds output `pix_count` [`COORD_W`:0].
  - Cleared on an accepted `draw_en`.
  - Increments on each handshake.
  - Holds its final value until the next start. Reset value is 0.
- `BLA_PIXEL_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `bresenham_pkg` holds:
  - `COORD_W` default constant
  - the state enum `bla_state_t` (IDLE, SETUP, DRAW, DONE)
  - a `pixel_t` struct {x, y}, shared with `bresenham_controller` and the framebuffer writer.
- One combinational sub-module, `bla_err_step`: takes cur x/y, err, dx, dy, sx, sy; returns next x/y and err. The top level holds the FSM, registers and handshake.

## Test plan
- **Horizontal line:** (0,0)→(3,0), `pix_ready`=1. Expect pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, `draw_done` one cycle after (3,0), `busy` low with it.
- **Steep negative line:** (5,5)→(3,0). Expect exactly (5,5),(5,4),(4,3),(4,2),(3,1),(3,0).
- **Degenerate line:** (7,9)→(7,9). Expect a single pixel (7,9), then `draw_done`. With the macro, `pix_count`=1.
- **Backpressure:** (0,0)→(3,0) with `pix_ready` low for 3 cycles while (1,0) is presented. Expect (1,0) held stable, no skipped or duplicated pixel, and `draw_done` 3 cycles later than the stall-free case.
- **Ignored request and reset:** a `draw_en` pulse during DRAW with different endpoints has no effect on the stream. Asserting `rst` mid-line gives `pix_valid`=0 and `busy`=0 immediately, and no `draw_done`.
- **Full-range diagonal:** (0,0)→(255,255). Expect 256 pixels ending at (255,255) with no wrap. With the macro, `pix_count`=256.
